// File: rtl/proc_mc.sv
// proc_mc: multicycle 16-bit-encoded core on a single req/ack memory bus.
// FETCH -> EXEC -> (MEM) -> FETCH, with a terminal HALT state left only by reset.
// Bus outputs are registered from the next state. They are therefore clean
// after reset, and they cannot depend combinationally on i_mem_ack.
module proc_mc #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_ack,
  output logic            o_halt,
  output logic [XLEN-1:0] o_pc
);
  localparam int unsigned     ShW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] PcStep  = XLEN'(2);
  localparam logic [XLEN-1:0] LdaStep = XLEN'(2 + XLEN / 8);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [15:0]     r_ir;
  // Register 0 is hardwired to zero, so it has no storage.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic            r_req, r_we, w_req_d, w_we_d;
  logic [XLEN-1:0] r_addr, r_wdata, w_addr_d, w_wdata_d;

  logic            w_ack;
  logic [1:0]      w_fmt;
  logic [3:0]      w_inst;
  logic [4:0]      w_ra_idx, w_rb_idx;
  logic [XLEN-1:0] w_ra, w_rb, w_alu, w_rf_wdata;
  logic            w_rf_we, w_is_halt, w_is_mem;

  // An ack is only honoured while a request is actually out.
  assign w_ack     = r_req & i_mem_ack;
  assign w_fmt     = r_ir[15:14];
  assign w_inst    = r_ir[13:10];
  assign w_ra_idx  = r_ir[9:5];
  assign w_rb_idx  = r_ir[4:0];
  assign w_is_halt = (w_fmt == 2'b00) && (w_inst == 4'hF);
  assign w_is_mem  = (w_fmt == 2'b01) || (w_fmt == 2'b10);

  // Operand read: index 0 and indices >= NREGS read as zero.
  always_comb begin
    w_ra = '0;
    w_rb = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (w_ra_idx == 5'(i)) w_ra = r_regs[i];
      if (w_rb_idx == 5'(i)) w_rb = r_regs[i];
    end
  end

  // ALU result for fmt 00.
  always_comb begin
    case (w_inst)
      4'h0:    w_alu = w_rb + w_ra;
      4'h1:    w_alu = w_rb - w_ra;
      4'h2:    w_alu = w_rb & w_ra;
      4'h3:    w_alu = w_rb | w_ra;
      4'h4:    w_alu = w_rb ^ w_ra;
      4'h5:    w_alu = w_rb << w_ra[ShW-1:0];
      4'h6:    w_alu = w_rb >> w_ra[ShW-1:0];
      4'h7:    w_alu = w_ra;
      4'h8:    w_alu = ~w_ra;
      4'h9:    w_alu = {{(XLEN-1){1'b0}}, (w_rb < w_ra)};
      default: w_alu = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= StFetch;
    else        r_state <= w_state_d;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StFetch: if (w_ack) w_state_d = StExec;
      StExec: begin
        if (w_is_halt)     w_state_d = StHalt;
        else if (w_is_mem) w_state_d = StMem;
        else               w_state_d = StFetch;
      end
      StMem:   if (w_ack) w_state_d = StFetch;
      StHalt:  w_state_d = StHalt;
    endcase
  end

  // FSM outputs: next bus request, held unchanged while a transfer waits.
  always_comb begin
    w_req_d   = 1'b0;
    w_we_d    = 1'b0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    unique case (w_state_d)
      StFetch: begin
        w_req_d  = 1'b1;
        w_addr_d = w_pc_d;
      end
      StMem: begin
        w_req_d = 1'b1;
        if (r_state == StMem) begin
          w_we_d    = r_we;
          w_addr_d  = r_addr;
          w_wdata_d = r_wdata;
        end else if (w_fmt == 2'b10) begin
          w_we_d    = 1'b1;
          w_addr_d  = w_rb;
          w_wdata_d = w_ra;
        end else if (w_inst[0]) begin
          w_addr_d = r_pc + PcStep;
        end else begin
          w_addr_d = w_ra;
        end
      end
      default: ;
    endcase
  end

  // PC update and register writeback on the edge that leaves EXEC or MEM.
  always_comb begin
    w_pc_d     = r_pc;
    w_rf_we    = 1'b0;
    w_rf_wdata = w_alu;
    if (r_state == StExec) begin
      unique case (w_fmt)
        2'b00: begin
          if (!w_is_halt) w_pc_d = r_pc + PcStep;
          w_rf_we = (w_inst <= 4'h9);
        end
        2'b11:   w_pc_d = (w_ra != '0) ? w_rb : r_pc + PcStep;
        default: ;
      endcase
    end else if ((r_state == StMem) && w_ack) begin
      w_pc_d     = r_pc + (((w_fmt == 2'b01) && w_inst[0]) ? LdaStep : PcStep);
      w_rf_we    = (w_fmt == 2'b01);
      w_rf_wdata = i_mem_rdata;
    end
  end

  // PC, instruction register and registered bus outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_pc    <= w_pc_d;
      if ((r_state == StFetch) && w_ack) r_ir <= i_mem_rdata[15:0];
      r_req   <= w_req_d;
      r_we    <= w_we_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
    end
  end

  // Register file; writes to r0 or to indices >= NREGS are dropped.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_rb_idx == 5'(i)) r_regs[i] <= w_rf_wdata;
      end
    end
  end

  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_halt      = (r_state == StHalt);
  assign o_pc        = r_pc;

endmodule
